// File: rtl/alu_pkg.sv
// Shared opcode and flag-index constants for the pipelined ALU.
package alu_pkg;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_NEG   = 3;
  localparam int NUM_FLAGS  = 4;

  localparam int STAGES = 2;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one shared adder serves ADD, SUB and SLT.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic             c_msb;
  logic             s_ovf;

  // Everything other than ADD subtracts; only ADD/SUB/SLT consume the sum.
  assign sub   = (op != OP_ADD);
  assign bx    = sub ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(sub);
  // Carry into the MSB recovered from the MSB sum bit and its operands.
  assign c_msb = sum[WIDTH-1] ^ a[WIDTH-1] ^ bx[WIDTH-1];
  assign s_ovf = c_msb ^ sum[WIDTH];

  always_comb begin
    r     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        r     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = s_ovf;
      end
      OP_SLT: begin
        r   = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ s_ovf};
        ovf = s_ovf;
      end
      OP_XOR:  r = a ^ b;
      OP_AND:  r = a & b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_OR:   r = a | b;
      default: r = '0;
    endcase
  end

  assign zero = (r == '0);
  assign neg  = r[WIDTH-1];
endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with tag passthrough and sticky carry/overflow.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic             sticky_carry,
  output logic             sticky_ovf,
  input  logic             sticky_clr
);
  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0]     r;
    logic [NUM_FLAGS-1:0] flags;
    logic [TAG_W-1:0]     tag;
  } rsp_t;

  logic [STAGES:1] vld_pipe;
  req_t            s1;
  rsp_t            s2;
  rsp_t            core_rsp;
  logic [WIDTH-1:0] core_r;
  logic            core_carry, core_ovf, core_zero, core_neg;
  logic            s1_adv, s2_adv, hs;

  assign s2_adv   = !vld_pipe[2] || out_ready;
  assign s1_adv   = !vld_pipe[1] || s2_adv;
  assign in_ready = s1_adv;
  assign hs       = vld_pipe[2] && out_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op    (s1.op),
    .a     (s1.a),
    .b     (s1.b),
    .r     (core_r),
    .carry (core_carry),
    .ovf   (core_ovf),
    .zero  (core_zero),
    .neg   (core_neg)
  );

  always_comb begin
    core_rsp                   = '0;
    core_rsp.r                 = core_r;
    core_rsp.tag               = s1.tag;
    core_rsp.flags[FLAG_CARRY] = core_carry;
    core_rsp.flags[FLAG_OVF]   = core_ovf;
    core_rsp.flags[FLAG_ZERO]  = core_zero;
    core_rsp.flags[FLAG_NEG]   = core_neg;
  end

  // Data registers only load with a valid op so outputs hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1 <= '{op: in_op, a: in_a, b: in_b, tag: in_tag};
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2 <= core_rsp;
      end
    end
  end

  // Clear wins over history but not over the flag emitted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_carry <= 1'b0;
      sticky_ovf   <= 1'b0;
    end else begin
      sticky_carry <= (sticky_clr ? 1'b0 : sticky_carry) | (hs & out_carry);
      sticky_ovf   <= (sticky_clr ? 1'b0 : sticky_ovf)   | (hs & out_ovf);
    end
  end

  assign out_valid  = vld_pipe[2];
  assign out_result = s2.r;
  assign out_tag    = s2.tag;
  assign out_carry  = s2.flags[FLAG_CARRY];
  assign out_ovf    = s2.flags[FLAG_OVF];
  assign out_zero   = s2.flags[FLAG_ZERO];
  assign out_neg    = s2.flags[FLAG_NEG];
endmodule
